// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and buffer-entry layout for the fetch unit
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'd0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer: registered pointers, flush, combinational head read
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with one-cycle memory and prefetch buffer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                   DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                   DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    output logic [DATAWIDTH-1:0] imem_addr_o,
    input  logic                 imem_ready_i,
    input  logic                 imem_rvalid_i,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [DATAWIDTH-1:0] redirect_pc_i,
    output logic                 inst_valid_o,
    output logic [DATAWIDTH-1:0] inst_o,
    output logic [DATAWIDTH-1:0] inst_pc_o,
    input  logic                 inst_ready_i
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DATAWIDTH-1:0]   pc_q, pc_d;
    logic [DATAWIDTH-1:0]   req_pc_q, req_pc_d;
    logic                   in_flight_q, in_flight_d;
    logic                   discard_q, discard_d;
    logic [CW-1:0]          count;
    logic [CW-1:0]          pending;
    logic [2*DATAWIDTH-1:0] head;
    logic                   accept, push, pop;

    fetch_fifo #(
        .WIDTH (2 * DATAWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i ({req_pc_q, imem_rdata_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        // an outstanding request reserves a slot so a response never lands in a full buffer
        pending      = count + CW'(in_flight_q);
        imem_req_o   = rst_i && !redirect_i && (pending < CW'(DEPTH));
        imem_addr_o  = pc_q;
        accept       = imem_req_o && imem_ready_i;
        inst_valid_o = rst_i && (count != '0);
        pop          = inst_valid_o && inst_ready_i;
        push         = imem_rvalid_i && in_flight_q && !discard_q && !redirect_i;
        inst_o       = inst_valid_o ? head[DATAWIDTH-1:0] : '0;
        inst_pc_o    = inst_valid_o ? head[2*DATAWIDTH-1:DATAWIDTH] : '0;

        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        in_flight_d = accept;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[DATAWIDTH-1:2], 2'b00};
        end else if (accept) begin
            pc_d     = pc_q + DATAWIDTH'(INSTR_BYTES);
            req_pc_d = pc_q;
        end
        discard_d = redirect_i && in_flight_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            in_flight_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i = 1'b0;

    fetch_unit #(.DATAWIDTH(32), .RESET_PC(32'd0), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: a queue of buffered instructions plus the one outstanding read
    logic [31:0]  m_pc = '0;
    fetch_entry_t m_q[$];
    bit           m_pend = 1'b0;
    logic [31:0]  m_pend_pc = '0;

    bit          resp_pending = 1'b0;
    logic [31:0] resp_data = '0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    typedef struct {
        bit          iready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit red, input logic [31:0] rpc,
                         input bit mready, input bit iready, input bit spurious,
                         input bit use_model);
        bit           e_req, e_valid, acc, deliver;
        fetch_entry_t head;
        logic [31:0]  acc_addr;
        rst_i         = rst;
        redirect_i    = red;
        redirect_pc_i = rpc;
        imem_ready_i  = mready;
        inst_ready_i  = iready;
        imem_rvalid_i = resp_pending || spurious;
        imem_rdata_i  = resp_pending ? resp_data : $urandom;
        #3;
        s_req = imem_req_o; s_addr = imem_addr_o; s_valid = inst_valid_o;
        s_pc = inst_pc_o; s_inst = inst_o;

        e_req   = rst && !red && (m_q.size() + int'(m_pend) < DEPTH);
        e_valid = rst && (m_q.size() > 0);
        head    = '0;
        if (e_valid) head = m_q[0];
        if (use_model) begin
            chk("model_req", s_req, e_req);
            chk("model_addr", s_addr, m_pc);
            chk("model_valid", s_valid, e_valid);
            chk("model_pc", s_pc, head.pc);
            chk("model_inst", s_inst, head.inst);
        end
        acc      = s_req && mready;
        acc_addr = s_addr;

        deliver = imem_rvalid_i && m_pend;
        if (!rst) begin
            m_pc = 32'd0; m_q.delete(); m_pend = 1'b0;
        end else if (red) begin
            m_q.delete(); m_pc = rpc & ~32'h3; m_pend = 1'b0;
        end else begin
            if (e_valid && iready) void'(m_q.pop_front());
            if (deliver) m_q.push_back('{pc: m_pend_pc, inst: imem_rdata_i});
            m_pend = e_req && mready;
            if (m_pend) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        resp_pending = acc;
        resp_data    = acc_addr + 32'h100;
    endtask

    task automatic set_row(input int i, input bit ir, input bit rq, input logic [31:0] ad,
                           input bit vl, input logic [31:0] pc);
        tbl[i] = '{iready: ir, e_req: rq, e_addr: ad, e_valid: vl, e_pc: pc};
    endtask

    initial begin
        set_row(0, 1, 1, 32'd0,  0, 32'd0);
        set_row(1, 1, 1, 32'd4,  0, 32'd0);
        set_row(2, 1, 1, 32'd8,  1, 32'd0);
        set_row(3, 1, 1, 32'd12, 1, 32'd4);
        set_row(4, 1, 1, 32'd16, 1, 32'd8);
        set_row(5, 1, 1, 32'd20, 1, 32'd12);
        set_row(6, 0, 1, 32'd24, 1, 32'd16);
        set_row(7, 0, 1, 32'd28, 1, 32'd16);
        for (int i = 8; i < 16; i++) set_row(i, 0, 0, 32'd32, 1, 32'd16);
        set_row(16, 1, 0, 32'd32, 1, 32'd16);
        set_row(17, 1, 1, 32'd32, 1, 32'd20);
        set_row(18, 1, 1, 32'd36, 1, 32'd24);
        set_row(19, 1, 1, 32'd40, 1, 32'd28);
        set_row(20, 1, 1, 32'd44, 1, 32'd32);
        set_row(21, 1, 1, 32'd48, 1, 32'd36);

        @(posedge clk); #1;
        cycle(0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 1);

        // fill, throughput, 10-cycle stall and resume
        for (int i = 0; i < 22; i++) begin
            cycle(1, 0, 0, 1, tbl[i].iready, 0, 1);
            chk($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_valid ? tbl[i].e_pc : 32'd0);
            chk($sformatf("tbl%0d_inst", i), s_inst, tbl[i].e_valid ? tbl[i].e_pc + 32'h100 : 32'd0);
        end

        // redirect to 0x45 with a response in flight
        cycle(1, 1, 32'h45, 1, 1, 0, 1);
        chk("redir_req_low", s_req, 1'b0);
        cycle(1, 0, 0, 1, 1, 0, 1);
        chk("redir_first_addr", s_addr, 32'h44);
        chk("redir_first_req", s_req, 1'b1);
        chk("redir_flushed", s_valid, 1'b0);
        cycle(1, 0, 0, 1, 1, 0, 1);
        chk("redir_drop", s_valid, 1'b0);
        cycle(1, 0, 0, 1, 1, 0, 1);
        chk("redir_head_pc", s_pc, 32'h44);
        chk("redir_head_inst", s_inst, 32'h144);

        // back-to-back redirects, last wins
        cycle(1, 1, 32'h100, 1, 1, 0, 1);
        cycle(1, 1, 32'h200, 1, 1, 0, 1);
        cycle(1, 0, 0, 1, 1, 0, 1);
        chk("b2b_addr", s_addr, 32'h200);

        // PC wrap at the top of the address space
        cycle(1, 1, 32'hFFFF_FFFF, 1, 1, 0, 1);
        cycle(1, 0, 0, 1, 1, 0, 1);
        chk("wrap_top", s_addr, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 1, 1, 0, 1);
        chk("wrap_zero", s_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 1, 0, 1);

        // reset mid-stream with a read outstanding, stale response after release
        cycle(0, 0, 0, 1, 0, 0, 1);
        chk("mrst_req", s_req, 1'b0);
        chk("mrst_valid", s_valid, 1'b0);
        chk("mrst_inst", s_inst, 32'd0);
        chk("mrst_pc", s_pc, 32'd0);
        cycle(1, 0, 0, 1, 1, 1, 1);
        chk("mrst_after_valid", s_valid, 1'b0);
        chk("mrst_after_addr", s_addr, 32'd0);
        cycle(1, 0, 0, 1, 1, 1, 1);
        cycle(1, 0, 0, 1, 1, 0, 1);
        chk("mrst_restart_pc", s_pc, 32'd0);
        chk("mrst_restart_inst", s_inst, 32'h100);

        // memory ready alternating every cycle, decode always ready
        for (int i = 0; i < 40; i++) cycle(1, 0, 0, (i % 2) == 0, 1, 0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_red, r_mr, r_ir, r_sp;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) != 0);
            r_red = ($urandom_range(0, 99) < 4);
            r_pc  = $urandom;
            if ($urandom_range(0, 7) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
            r_mr  = ($urandom_range(0, 9) < 7);
            r_ir  = ($urandom_range(0, 3) != 0);
            r_sp  = !resp_pending && ($urandom_range(0, 9) == 0);
            cycle(r_rst, r_red, r_pc, r_mr, r_ir, r_sp, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
